// File: rtl/key_event_if.sv
// Event bundle for one push-button: the raw active-low key level going in and
// the debounced level plus single-cycle event pulses coming out.
interface key_event_if;
    logic button_n;
    logic held;
    logic press;
    logic click;
    logic long_press;
    logic rpt;

    modport master (
        output button_n,
        input  held,
        input  press,
        input  click,
        input  long_press,
        input  rpt
    );

    modport slave (
        input  button_n,
        output held,
        output press,
        output click,
        output long_press,
        output rpt
    );
endinterface

// File: rtl/key_event.sv
// Per-button synchroniser, debouncer and press/click/long-press/auto-repeat event generator.
// Auto-repeat pulses are built only when KEY_EVENT_AUTOREPEAT_EN is defined.
module key_event #(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LONG_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    key_event_if.slave  ev
);

    localparam int MAX_AB  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_EVENT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEB_DN = 3'd1,
        HELD   = 3'd2,
        LONG   = 3'd3,
        DEB_UP = 3'd4
    } state_t;

    logic [1:0]       sync_reg;
    logic             btn;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             long_flag_reg, long_flag_next;
    logic             press_reg, press_next;
    logic             click_reg, click_next;
    logic             long_reg, long_next;
    logic             held_int;

    // Released (1) is the safe reset level so a held key is re-debounced after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], ev.button_n};
        end
    end

    assign btn = ~sync_reg[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            long_flag_reg <= 1'b0;
            press_reg     <= 1'b0;
            click_reg     <= 1'b0;
            long_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            long_flag_reg <= long_flag_next;
            press_reg     <= press_next;
            click_reg     <= click_next;
            long_reg      <= long_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        long_flag_next = long_flag_reg;
        case (state_reg)
            IDLE: begin
                if (btn) begin
                    state_next = DEB_DN;
                    cnt_next   = '0;
                end
            end
            DEB_DN: begin
                if (!btn) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next     = HELD;
                    cnt_next       = '0;
                    long_flag_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!btn) begin
                    state_next = DEB_UP;
                    cnt_next   = '0;
                end else if (cnt_reg == LONG_LAST) begin
                    state_next     = LONG;
                    cnt_next       = '0;
                    long_flag_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LONG: begin
                if (!btn) begin
                    state_next = DEB_UP;
                    cnt_next   = '0;
                end else begin
`ifdef KEY_EVENT_AUTOREPEAT_EN
                    cnt_next = (cnt_reg == RPT_LAST) ? '0 : cnt_reg + 1'b1;
`else
                    cnt_next = '0;
`endif
                end
            end
            DEB_UP: begin
                // A bounce back to pressed resumes the hold without a fresh press event.
                if (btn) begin
                    state_next = long_flag_reg ? LONG : HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        press_next = (state_reg == DEB_DN) && btn && (cnt_reg == DEB_LAST);
        click_next = (state_reg == DEB_UP) && !btn && (cnt_reg == DEB_LAST) && !long_flag_reg;
        long_next  = (state_reg == HELD) && btn && (cnt_reg == LONG_LAST);
        held_int   = (state_reg == HELD) || (state_reg == LONG) || (state_reg == DEB_UP);
    end

`ifdef KEY_EVENT_AUTOREPEAT_EN
    logic rpt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_reg <= 1'b0;
        end else begin
            rpt_reg <= (state_reg == LONG) && btn && (cnt_reg == RPT_LAST);
        end
    end

    assign ev.rpt = rpt_reg;
`else
    assign ev.rpt = 1'b0;
`endif

    assign ev.held       = held_int;
    assign ev.press      = press_reg;
    assign ev.click      = click_reg;
    assign ev.long_press = long_reg;

endmodule
